// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit: restoring division, one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            KILL,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OP_1,
  input  logic [XLEN-1:0] OP_2,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] dvd_q, dsr_q, rem_q, quo_q;
  logic            sel_rem_q, neg_q_q, neg_r_q;
  logic [XLEN-1:0] result_q;

  logic            funct3_unused;
  logic            is_signed;
  logic [XLEN-1:0] mag_1, mag_2;
  logic            div_zero, ovf, fast;
  logic [XLEN-1:0] fast_result;
  logic            accept;

  logic [XLEN:0]   rem_shift, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt, quo_nxt, final_result;

  assign funct3_unused = FUNCT3[2];

  // Operand conditioning at accept time
  assign is_signed   = ~FUNCT3[0];
  assign mag_1       = (is_signed && OP_1[XLEN-1]) ? -OP_1 : OP_1;
  assign mag_2       = (is_signed && OP_2[XLEN-1]) ? -OP_2 : OP_2;
  assign div_zero    = (OP_2 == '0);
  assign ovf         = is_signed && (OP_1 == MIN_INT) && (OP_2 == '1);
  assign fast        = div_zero || ovf;
  assign fast_result = div_zero ? (FUNCT3[1] ? OP_1 : '1)
                                : (FUNCT3[1] ? '0   : MIN_INT);

  // One restoring step; partial remainder stays below divisor, so bit XLEN of diff is the borrow
  assign rem_shift    = {rem_q, dvd_q[XLEN-1]};
  assign diff         = rem_shift - {1'b0, dsr_q};
  assign q_bit        = ~diff[XLEN];
  assign rem_nxt      = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_nxt      = {quo_q[XLEN-2:0], q_bit};
  assign final_result = sel_rem_q ? (neg_r_q ? -rem_nxt : rem_nxt)
                                  : (neg_q_q ? -quo_nxt : quo_nxt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = fast ? S_DONE : S_CALC;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (count_q == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (KILL) begin
      state_nxt = S_IDLE;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q   <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      sel_rem_q <= FUNCT3[1];
      neg_q_q   <= is_signed && (OP_1[XLEN-1] ^ OP_2[XLEN-1]);
      neg_r_q   <= is_signed && OP_1[XLEN-1];
      dvd_q     <= mag_1;
      dsr_q     <= mag_2;
      rem_q     <= '0;
      quo_q     <= '0;
      count_q   <= CW'(XLEN-1);
      if (fast) result_q <= fast_result;
    end else if (state_q == S_CALC && !KILL) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
      if (count_q == '0) result_q <= final_result;
      else               count_q  <= count_q - 1'b1;
    end
  end

  assign RESULT = result_q;
  assign BUSY   = (state_q == S_CALC);
  assign DONE   = (state_q == S_DONE);

endmodule
